// File: rtl/adder_arb_pkg.sv
// ============================================================================
// Module      : adder_arb_pkg
// Description : Shared types, widths and round-robin helper for adder_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_arb_pkg;

  localparam int ADD_W  = 15;
  localparam int WIDE_W = 30;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  // First set bit of req scanning ptr, ptr+1, ... modulo n (n <= 8).
  function automatic int rr_pick(input logic [7:0] req, input int ptr, input int n);
    int   win;
    int   cand;
    logic found;
    win   = 0;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k < n && !found) begin
        cand = (ptr + k) % n;
        if (req[3'(cand)]) begin
          win   = cand;
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adder.sv
// ============================================================================
// Module      : adder
// Description : 15-bit ripple-carry adder slice (A + B + C -> S, C_out).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder
  import adder_arb_pkg::*;
(
  input  logic [ADD_W-1:0] A,
  input  logic [ADD_W-1:0] B,
  input  logic             C,
  output logic [ADD_W-1:0] S,
  output logic             C_out
);

  logic [ADD_W:0] w_c;

  assign w_c[0] = C;

  generate
    for (genvar i = 0; i < ADD_W; i++) begin : g_bit
      assign S[i]     = A[i] ^ B[i] ^ w_c[i];
      assign w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
    end
  endgenerate

  assign C_out = w_c[ADD_W];

endmodule

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin winner select with valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  win,
  output logic             valid
);

  import adder_arb_pkg::*;

  logic [7:0] w_req_ext;

  always_comb begin
    w_req_ext              = '0;
    w_req_ext[N_REQ-1:0]   = req;
  end

  assign win   = ID_W'(rr_pick(w_req_ext, int'(ptr), N_REQ));
  assign valid = |req;

endmodule

`default_nettype wire

// File: rtl/adder_arbiter.sv
// ============================================================================
// Module      : adder_arbiter
// Description : Round-robin sharing of one 15-bit adder; 30-bit adds done in
//               two chained passes with a registered result and done strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int ADD_W = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   wide,
  input  logic [N_REQ-1:0]   cin,
  input  logic [N_REQ*30-1:0] a_in,
  input  logic [N_REQ*30-1:0] b_in,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic [29:0]        sum_out,
  output logic               cout_out,
  output logic               busy
);

  import adder_arb_pkg::*;

  state_t              r_state;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_id;
  logic [WIDE_W-1:0]   r_a;
  logic [WIDE_W-1:0]   r_b;
  logic [WIDE_W-1:0]   r_sum;
  logic                r_cin;
  logic                r_wide;
  logic                r_carry;
  logic                r_cout;
  logic [N_REQ-1:0]    r_gnt;
  logic [N_REQ-1:0]    r_done;

  logic [ID_W-1:0]     w_win;
  logic                w_valid;
  logic [ADD_W-1:0]    w_add_a;
  logic [ADD_W-1:0]    w_add_b;
  logic [ADD_W-1:0]    w_add_s;
  logic                w_add_c;
  logic                w_add_co;

  rr_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_picker (
    .req   (req),
    .ptr   (r_ptr),
    .win   (w_win),
    .valid (w_valid)
  );

  // Adder is held at zero outside LOW/HIGH so it never toggles when idle.
  always_comb begin
    w_add_a = '0;
    w_add_b = '0;
    w_add_c = 1'b0;
    case (r_state)
      LOW: begin
        w_add_a = r_a[ADD_W-1:0];
        w_add_b = r_b[ADD_W-1:0];
        w_add_c = r_cin;
      end
      HIGH: begin
        w_add_a = r_a[WIDE_W-1:ADD_W];
        w_add_b = r_b[WIDE_W-1:ADD_W];
        w_add_c = r_carry;
      end
      default: ;
    endcase
  end

  adder u_adder (
    .A     (w_add_a),
    .B     (w_add_b),
    .C     (w_add_c),
    .S     (w_add_s),
    .C_out (w_add_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_id    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cin   <= 1'b0;
      r_wide  <= 1'b0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_gnt   <= '0;
      r_done  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_id    <= w_win;
            r_a     <= a_in[w_win*WIDE_W +: WIDE_W];
            r_b     <= b_in[w_win*WIDE_W +: WIDE_W];
            r_cin   <= cin[w_win];
            r_wide  <= wide[w_win];
            r_gnt   <= N_REQ'(1) << w_win;
            r_state <= LOW;
          end
        end
        LOW: begin
          r_sum[ADD_W-1:0] <= w_add_s;
          if (r_wide) begin
            r_carry <= w_add_co;
            r_state <= HIGH;
          end else begin
            r_sum[WIDE_W-1:ADD_W] <= '0;
            r_cout                <= w_add_co;
            r_done                <= r_gnt;
            r_state               <= DONE;
          end
        end
        HIGH: begin
          r_sum[WIDE_W-1:ADD_W] <= w_add_s;
          r_cout                <= w_add_co;
          r_done                <= r_gnt;
          r_state               <= DONE;
        end
        DONE: begin
          r_done  <= '0;
          r_gnt   <= '0;
          r_ptr   <= (r_id == ID_W'(N_REQ - 1)) ? '0 : r_id + 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign done     = r_done;
  assign sum_out  = r_sum;
  assign cout_out = r_cout;
  assign busy     = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_adder_arbiter.sv
// ============================================================================
// Module      : tb_adder_arbiter
// Description : Self-checking bench for adder_arbiter with a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    wide = '0;
  logic [N-1:0]    cin = '0;
  logic [N*30-1:0] a_in = '0;
  logic [N*30-1:0] b_in = '0;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic [29:0]     sum_out;
  logic            cout_out;
  logic            busy;

  always #5 clk = ~clk;

  adder_arbiter #(.N_REQ(N), .ID_W(2), .ADD_W(15)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .wide     (wide),
    .cin      (cin),
    .a_in     (a_in),
    .b_in     (b_in),
    .gnt      (gnt),
    .done     (done),
    .sum_out  (sum_out),
    .cout_out (cout_out),
    .busy     (busy)
  );

  int checks = 0;
  int errors = 0;

  logic [N-1:0] hold = '0;
  logic [N-1:0] prev_gnt = '0;
  int           order[$];

  // Transaction model: cycles left in the current op, winner, and result.
  int          m_left = 0;
  int          m_ptr  = 0;
  int          m_id   = 0;
  logic [29:0] m_sum  = '0;
  logic        m_cout = 1'b0;
  logic        m_rst  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [30:0] t;
    logic [29:0] av;
    logic [29:0] bv;
    m_rst = 1'b0;
    if (rst) begin
      m_left = 0;
      m_ptr  = 0;
      m_sum  = '0;
      m_cout = 1'b0;
      m_rst  = 1'b1;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_ptr = (m_id + 1) % N;
    end else if (req != 0) begin
      for (int k = N - 1; k >= 0; k--)
        if (req[(m_ptr + k) % N]) m_id = (m_ptr + k) % N;
      av = a_in[m_id*30 +: 30];
      bv = b_in[m_id*30 +: 30];
      if (wide[m_id]) begin
        t      = {1'b0, av} + {1'b0, bv} + 31'(cin[m_id]);
        m_sum  = t[29:0];
        m_cout = t[30];
        m_left = 3;
      end else begin
        t      = 31'(av[14:0]) + 31'(bv[14:0]) + 31'(cin[m_id]);
        m_sum  = {15'd0, t[14:0]};
        m_cout = t[15];
        m_left = 2;
      end
    end
  endtask

  task automatic compare();
    logic [N-1:0] exp_g;
    logic [N-1:0] exp_d;
    exp_g = (m_left > 0) ? (N'(1) << m_id) : '0;
    exp_d = (m_left == 1) ? exp_g : '0;
    chk("gnt", 32'(gnt), 32'(exp_g));
    chk("done", 32'(done), 32'(exp_d));
    chk("busy", 32'(busy), 32'(m_left > 0));
    if (m_left == 1 || m_rst) begin
      chk("sum", 32'(sum_out), 32'(m_sum));
      chk("cout", 32'(cout_out), 32'(m_cout));
    end
  endtask

  // One clock: model advances on the edge, DUT checked 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
    if (gnt != 0 && prev_gnt == 0)
      for (int i = 0; i < N; i++) if (gnt[i]) order.push_back(i);
    prev_gnt = gnt;
    for (int i = 0; i < N; i++) if (done[i] && !hold[i]) req[i] = 1'b0;
  endtask

  task automatic set_op(input int i, input logic w, input logic c,
                        input logic [29:0] a, input logic [29:0] b);
    wide[i]         = w;
    cin[i]          = c;
    a_in[i*30 +: 30] = a;
    b_in[i*30 +: 30] = b;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic run_quiet(input int bound);
    int n = 0;
    while ((req != 0 || busy) && n < bound) begin
      step();
      n++;
    end
    chk("quiet_timeout", 32'(req == 0 && !busy), 32'd1);
  endtask

  task automatic run_op(input int i, input logic w, input logic c,
                        input logic [29:0] a, input logic [29:0] b,
                        input logic [29:0] exp_s, input logic exp_c, input int exp_lat);
    int   lat = 0;
    logic seen = 1'b0;
    wait_idle();
    set_op(i, w, c, a, b);
    req[i] = 1'b1;
    while (!seen && lat < 10) begin
      step();
      lat++;
      if (done[i]) seen = 1'b1;
    end
    chk("op_seen", 32'(seen), 32'd1);
    chk("op_latency", 32'(lat), 32'(exp_lat));
    chk("op_sum", 32'(sum_out), 32'(exp_s));
    chk("op_cout", 32'(cout_out), 32'(exp_c));
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum_out), 32'd0);
    chk("rst_cout", 32'(cout_out), 32'd0);
    rst = 1'b0;

    // Narrow and wide directed vectors
    run_op(0, 1'b0, 1'b0, 30'h34,       30'h15,   30'h49,       1'b0, 2);
    run_op(1, 1'b0, 1'b0, 30'h34,       30'h7FFE, 30'h32,       1'b1, 2);
    run_op(1, 1'b0, 1'b0, 30'h7FFE,     30'h7FFE, 30'h7FFC,     1'b1, 2);
    run_op(2, 1'b1, 1'b0, 30'h7FFF,     30'h1,    30'h8000,     1'b0, 3);
    run_op(2, 1'b1, 1'b0, 30'h3FFFFFFF, 30'h1,    30'h0,        1'b1, 3);

    // Contention from reset: all four requesters, then 1 and 3
    wait_idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_op(0, 1'b0, 1'b0, 30'h100,      30'h23);
    set_op(1, 1'b1, 1'b1, 30'h12345678, 30'h0FEDCBA9);
    set_op(2, 1'b0, 1'b0, 30'h7FFF,     30'h1);
    set_op(3, 1'b1, 1'b0, 30'h3FFF8000, 30'h8000);
    order.delete();
    req = 4'b1111;
    run_quiet(60);
    chk("order_len", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("order_all", 32'((order.size() > i) ? order[i] : -1), 32'(i));

    order.delete();
    req = 4'b1010;
    run_quiet(30);
    chk("order2_len", 32'(order.size()), 32'd2);
    chk("order2_first", 32'((order.size() > 0) ? order[0] : -1), 32'd1);
    chk("order2_second", 32'((order.size() > 1) ? order[1] : -1), 32'd3);

    // Reset in the middle of a wide op
    run_op(1, 1'b0, 1'b0, 30'h1, 30'h2, 30'h3, 1'b0, 2);
    wait_idle();
    step();
    set_op(2, 1'b1, 1'b0, 30'h7FFF, 30'h7FFF);
    req[2] = 1'b1;
    step();
    step();
    chk("midop_gnt", 32'(gnt), 32'h4);
    rst = 1'b1;
    step();
    chk("abort_gnt", 32'(gnt), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sum", 32'(sum_out), 32'd0);
    rst = 1'b0;
    req[2] = 1'b0;
    step();
    set_op(1, 1'b0, 1'b1, 30'h10,       30'h20);
    set_op(3, 1'b1, 1'b0, 30'h00012345, 30'h00054321);
    order.delete();
    req = 4'b1010;
    run_quiet(30);
    chk("post_rst_first", 32'((order.size() > 0) ? order[0] : -1), 32'd1);
    chk("post_rst_second", 32'((order.size() > 1) ? order[1] : -1), 32'd3);

    // Held request re-served after a single idle cycle
    begin
      int n = 0;
      hold[0] = 1'b1;
      set_op(0, 1'b0, 1'b0, 30'h5, 30'h6);
      req[0] = 1'b1;
      while (!done[0] && n < 10) begin
        step();
        n++;
      end
      chk("held_done", 32'(done[0]), 32'd1);
      chk("held_sum", 32'(sum_out), 32'hB);
      step();
      chk("held_gap_busy", 32'(busy), 32'd0);
      step();
      chk("held_regrant", 32'(gnt), 32'd1);
      chk("held_regrant_busy", 32'(busy), 32'd1);
      hold[0] = 1'b0;
      run_quiet(20);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
